// File: rtl/reg_file_pkg.sv
// Shared constants and clear-sequencer state encoding for the register file bank.
package reg_file_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

endpackage

// File: rtl/reg_file_clr_fsm.sv
// Clear sequencer: sweeps every entry to zero once per accepted clr_req,
// then pulses clr_done for one cycle.
module reg_file_clr_fsm
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req_i,
    output logic              busy_o,
    output logic              clr_done_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o
);

    localparam logic [ADDR_W-1:0] PTR_LAST = '1;
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // State, pointer and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and pointer logic; clr_req only matters in IDLE
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (clr_req_i) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                ptr_d = ptr_q + PTR_ONE;
                if (ptr_q == PTR_LAST) begin
                    state_d = DONE;
                end else begin
                    state_d = CLEAR;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // Outputs decoded from the next state so they register alongside it
    always_comb begin
        busy_d = (state_d == CLEAR);
        done_d = (state_d == DONE);
    end

    assign busy_o     = busy_q;
    assign clr_done_o = done_q;
    assign clr_we_o   = busy_q;
    assign clr_addr_o = ptr_q;

endmodule

// File: rtl/reg_file_bank.sv
// Byte-writable register file with two registered read ports, write-to-read
// bypass and a hardware clear sweep.
module reg_file_bank
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   rd_addr1,
    input  logic [ADDR_W-1:0]   rd_addr2,
    output logic [DATA_W-1:0]   rd_data1,
    output logic [DATA_W-1:0]   rd_data2,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                clr_req,
    output logic                busy,
    output logic                clr_done
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old_v;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;
    logic              clr_we_s;
    logic [ADDR_W-1:0] clr_addr_s;
    logic              user_we_s;

    reg_file_clr_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clr_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_req_i  (clr_req),
        .busy_o     (busy),
        .clr_done_o (clr_done),
        .clr_we_o   (clr_we_s),
        .clr_addr_o (clr_addr_s)
    );

    // User writes are dropped during a sweep and never touch a hard-wired entry 0
    always_comb begin
        user_we_s = wr_en && !busy && !(ZERO_REG && (wr_addr == '0));
    end

    // Post-write array image; reads sample it so same-cycle writes bypass
    always_comb begin
        mem_d = mem_q;
        if (clr_we_s) begin
            mem_d[clr_addr_s] = '0;
        end else if (user_we_s) begin
            mem_d[wr_addr] = byte_merge(mem_q[wr_addr], wr_data, wr_be);
        end else begin
            mem_d = mem_q;
        end
    end

    // Read port next values from the post-write image
    always_comb begin
        if (ZERO_REG && (rd_addr1 == '0)) begin
            rd1_d = '0;
        end else begin
            rd1_d = mem_d[rd_addr1];
        end
        if (ZERO_REG && (rd_addr2 == '0)) begin
            rd2_d = '0;
        end else begin
            rd2_d = mem_d[rd_addr2];
        end
    end

    // Storage array and read registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd1_q <= '0;
            rd2_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd1_q <= rd1_d;
            rd2_q <= rd2_d;
        end
    end

    assign rd_data1 = rd1_q;
    assign rd_data2 = rd2_q;

endmodule

// File: tb/tb_reg_file_bank.sv
// Directed self-checking bench for reg_file_bank: one DUT with a hard-wired
// entry 0 and one with an ordinary entry 0, driven by the same stimulus.
module tb_reg_file_bank;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] rd_addr1, rd_addr2, wr_addr;
    logic          wr_en, clr_req;
    logic [DW-1:0] wr_data;
    logic [BW-1:0] wr_be;
    logic [DW-1:0] rd_data1, rd_data2, rd1_nz, rd2_nz;
    logic          busy, clr_done, busy_nz, done_nz;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_file_bank #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .clr_req(clr_req), .busy(busy),
        .clr_done(clr_done)
    );

    reg_file_bank #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b0)) dut_nz (
        .clk(clk), .rst_n(rst_n), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd1_nz), .rd_data2(rd2_nz), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .clr_req(clr_req), .busy(busy_nz),
        .clr_done(done_nz)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_en = 1'b0; clr_req = 1'b0; wr_addr = '0;
        wr_data = '0; wr_be = '0; rd_addr1 = '0; rd_addr2 = '0;
        #2;
        checks++; if (rd_data1 !== 32'd0) begin failures++; $display("FAIL reset_rd1 got=%h exp=%h", rd_data1, 32'd0); end
        checks++; if (rd_data2 !== 32'd0) begin failures++; $display("FAIL reset_rd2 got=%h exp=%h", rd_data2, 32'd0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (clr_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", clr_done); end
        step();
        checks++; if (rd1_nz !== 32'd0) begin failures++; $display("FAIL reset_rd1_nz got=%h exp=%h", rd1_nz, 32'd0); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_write();
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'd75; wr_be = 4'hF;
        step();
        wr_en = 1'b0; rd_addr1 = 5'd4; rd_addr2 = 5'd28;
        step();
        checks++; if (rd_data1 !== 32'd75) begin failures++; $display("FAIL basic_rd1 got=%h exp=%h", rd_data1, 32'd75); end
        checks++; if (rd_data2 !== 32'd0) begin failures++; $display("FAIL basic_rd2 got=%h exp=%h", rd_data2, 32'd0); end
    endtask

    task automatic test_byte_bypass();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h1122_3344; wr_be = 4'hF;
        step();
        wr_data = 32'hAABB_CCDD; wr_be = 4'b0101; rd_addr1 = 5'd9; rd_addr2 = 5'd9;
        step();
        checks++; if (rd_data1 !== 32'h11BB_33DD) begin failures++; $display("FAIL be_bypass_rd1 got=%h exp=%h", rd_data1, 32'h11BB_33DD); end
        checks++; if (rd_data2 !== 32'h11BB_33DD) begin failures++; $display("FAIL be_bypass_rd2 got=%h exp=%h", rd_data2, 32'h11BB_33DD); end
        wr_data = 32'hFFFF_FFFF; wr_be = 4'h0;
        step();
        checks++; if (rd_data1 !== 32'h11BB_33DD) begin failures++; $display("FAIL be_zero got=%h exp=%h", rd_data1, 32'h11BB_33DD); end
    endtask

    task automatic test_back_to_back();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_00AA; wr_be = 4'b0001;
        step();
        wr_data = 32'h0000_BB00; wr_be = 4'b0010; rd_addr1 = 5'd7; rd_addr2 = 5'd4;
        step();
        wr_en = 1'b0;
        checks++; if (rd_data1 !== 32'h0000_BBAA) begin failures++; $display("FAIL b2b_rd1 got=%h exp=%h", rd_data1, 32'h0000_BBAA); end
        checks++; if (rd_data2 !== 32'd75) begin failures++; $display("FAIL b2b_rd2 got=%h exp=%h", rd_data2, 32'd75); end
    endtask

    task automatic test_zero_reg();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
        rd_addr1 = 5'd0; rd_addr2 = 5'd0;
        step();
        wr_en = 1'b0;
        checks++; if (rd_data1 !== 32'd0) begin failures++; $display("FAIL zero_byp_rd1 got=%h exp=%h", rd_data1, 32'd0); end
        checks++; if (rd1_nz !== 32'hFFFF_FFFF) begin failures++; $display("FAIL zero_byp_nz got=%h exp=%h", rd1_nz, 32'hFFFF_FFFF); end
        step();
        checks++; if (rd_data2 !== 32'd0) begin failures++; $display("FAIL zero_rd2 got=%h exp=%h", rd_data2, 32'd0); end
        checks++; if (rd2_nz !== 32'hFFFF_FFFF) begin failures++; $display("FAIL zero_rd2_nz got=%h exp=%h", rd2_nz, 32'hFFFF_FFFF); end
    endtask

    task automatic test_clear();
        logic          busy_h [36];
        logic          done_h [36];
        logic [DW-1:0] rd2_h  [36];
        int            busy_cnt;
        int            done_cnt;
        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = i[AW-1:0]; wr_data = 32'hA500_0000 + 32'(i + 1); wr_be = 4'hF;
            step();
        end
        // Simultaneous write and clear request: write lands, sweep starts after
        clr_req = 1'b1; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h0000_0055;
        rd_addr1 = 5'd5; rd_addr2 = 5'd20;
        step();
        clr_req = 1'b0; wr_en = 1'b0; wr_addr = 5'd2; wr_data = 32'h0000_0077;
        checks++; if (rd_data1 !== 32'h0000_0055) begin failures++; $display("FAIL clr_same_cycle_wr got=%h exp=%h", rd_data1, 32'h0000_0055); end
        for (int n = 1; n <= 35; n++) begin
            busy_h[n] = busy; done_h[n] = clr_done; rd2_h[n] = rd_data2;
            wr_en   = (n == 10);
            clr_req = (n == 33);
            step();
        end
        wr_en = 1'b0; clr_req = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        for (int n = 1; n <= 35; n++) begin
            if (busy_h[n] === 1'b1) busy_cnt++;
            if (done_h[n] === 1'b1) done_cnt++;
        end
        checks++; if (busy_cnt != 32) begin failures++; $display("FAIL clr_busy_cycles got=%0d exp=32", busy_cnt); end
        checks++; if (busy_h[1] !== 1'b1 || busy_h[32] !== 1'b1) begin failures++; $display("FAIL clr_busy_window got=%b%b exp=11", busy_h[1], busy_h[32]); end
        checks++; if (done_h[33] !== 1'b1 || busy_h[33] !== 1'b0) begin failures++; $display("FAIL clr_done_pulse got=%b/%b exp=1/0", done_h[33], busy_h[33]); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL clr_done_count got=%0d exp=1", done_cnt); end
        checks++; if (busy_h[34] !== 1'b0 || busy_h[35] !== 1'b0) begin failures++; $display("FAIL clr_req_in_done got=%b%b exp=00", busy_h[34], busy_h[35]); end
        checks++; if (rd2_h[21] !== 32'hA500_0015) begin failures++; $display("FAIL clr_rd_before got=%h exp=%h", rd2_h[21], 32'hA500_0015); end
        checks++; if (rd2_h[22] !== 32'd0) begin failures++; $display("FAIL clr_rd_bypass got=%h exp=%h", rd2_h[22], 32'd0); end
        for (int i = 0; i < 32; i++) begin
            rd_addr1 = i[AW-1:0];
            step();
            checks++; if (rd_data1 !== 32'd0) begin failures++; $display("FAIL clr_entry_%0d got=%h exp=%h", i, rd_data1, 32'd0); end
            checks++; if (rd1_nz !== 32'd0) begin failures++; $display("FAIL clr_entry_nz_%0d got=%h exp=%h", i, rd1_nz, 32'd0); end
        end
    endtask

    task automatic test_reset_mid_clear();
        int bad;
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h0000_ABCD; wr_be = 4'hF; rd_addr1 = 5'd31;
        step();
        wr_en = 1'b0; clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int n = 1; n < 10; n++) step();
        checks++; if (busy !== 1'b1 || rd_data1 !== 32'h0000_ABCD) begin failures++; $display("FAIL rst_mid_pre got=%b/%h exp=1/%h", busy, rd_data1, 32'h0000_ABCD); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (rd_data1 !== 32'd0) begin failures++; $display("FAIL rst_mid_rd1 got=%h exp=%h", rd_data1, 32'd0); end
        checks++; if (rd_data2 !== 32'd0) begin failures++; $display("FAIL rst_mid_rd2 got=%h exp=%h", rd_data2, 32'd0); end
        checks++; if (busy !== 1'b0 || clr_done !== 1'b0) begin failures++; $display("FAIL rst_mid_ctl got=%b/%b exp=0/0", busy, clr_done); end
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (busy !== 1'b0 || clr_done !== 1'b0) bad++;
        end
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'd5; wr_be = 4'hF;
        rst_n = 1'b1;
        step();
        wr_en = 1'b0; rd_addr1 = 5'd3; rd_addr2 = 5'd31;
        step();
        checks++; if (rd_data1 !== 32'd5) begin failures++; $display("FAIL rst_first_write got=%h exp=%h", rd_data1, 32'd5); end
        checks++; if (rd_data2 !== 32'd0) begin failures++; $display("FAIL rst_array_cleared got=%h exp=%h", rd_data2, 32'd0); end
        for (int k = 0; k < 35; k++) begin
            if (busy !== 1'b0 || clr_done !== 1'b0) bad++;
            step();
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL rst_no_resume got=%0d exp=0", bad); end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_byte_bypass();
        test_back_to_back();
        test_zero_reg();
        test_clear();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/reg_file_bank.md
REG_FILE_BANK -- requirements
Module: reg_file_bank

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  DATA_W, 32, word width in bits; SHALL be a multiple of 8.
  ADDR_W, 5, address width; depth SHALL be 2**ADDR_W entries.
  ZERO_REG, 1, when 1, entry 0 SHALL be hard-wired to zero.
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  in  1  single clock, rising-edge active.
  rst_n  in  1  reset, asynchronous, active-low.
  rd_addr1  in  ADDR_W  read port 1 address.
  rd_addr2  in  ADDR_W  read port 2 address.
  rd_data1  out  DATA_W  read port 1 data, registered.
  rd_data2  out  DATA_W  read port 2 data, registered.
  wr_en  in  1  write request.
  wr_addr  in  ADDR_W  write address.
  wr_data  in  DATA_W  write data.
  wr_be  in  DATA_W/8  byte enables; bit i covers wr_data[8i+7:8i].
  clr_req  in  1  request a full-array clear.
  busy  out  1  high while the clear sweep is in progress.
  clr_done  out  1  one-cycle pulse when the clear sweep completes.

Function
REQ-003 Writes SHALL commit on the rising edge when wr_en=1 and busy=0, updating only the bytes whose wr_be bit is 1.
REQ-004 wr_en=1 with wr_be all zero SHALL leave the array unchanged.
REQ-005 wr_en=1 while busy=1 SHALL be dropped, with no retry.
REQ-006 At each rising edge, each rd_dataN SHALL load the contents of rd_addrN; read latency is 1 cycle.
REQ-007 Bypass: when a committed write (user or clear) targets rd_addrN in the same cycle, rd_dataN SHALL load the post-write byte-merged value.
REQ-008 Both read ports SHALL operate independently, including when both use the same address.
REQ-009 With ZERO_REG=1, writes to address 0 SHALL be ignored and reads of address 0 SHALL return 0. With ZERO_REG=0, entry 0 SHALL be an ordinary entry.
REQ-010 The clear FSM SHALL have three states: IDLE, CLEAR, DONE.
REQ-011 IDLE -> CLEAR SHALL occur on clr_req=1, with the sweep pointer set to 0.
REQ-012 In CLEAR, each cycle SHALL write all-zero to the pointer entry and increment the pointer. After the entry 2**ADDR_W-1 is written, the FSM SHALL go to DONE. A sweep SHALL take exactly 2**ADDR_W cycles.
REQ-013 DONE -> IDLE SHALL occur unconditionally after one cycle.
REQ-014 busy SHALL be 1 only in CLEAR. clr_done SHALL be 1 only in DONE.
REQ-015 clr_req SHALL be ignored in CLEAR and DONE; it does not queue.
REQ-016 When clr_req=1 and wr_en=1 arrive together in IDLE, the write SHALL commit in that cycle and the sweep SHALL start the following cycle.
REQ-017 During CLEAR, reads SHALL return the current array contents, with the REQ-007 bypass applied to the clear write.
REQ-018 The pointer SHALL be ADDR_W bits wide. Wrap-around to 0 at the end of the sweep SHALL not trigger a further sweep.

Reset
REQ-019 While rst_n=0, the following SHALL hold immediately, independent of clk: every entry is 0, rd_data1=rd_data2=0, the FSM is in IDLE, the pointer is 0, busy=0, clr_done=0.
REQ-020 Reset asserted during CLEAR SHALL abort the sweep with no clr_done pulse.
REQ-021 After rst_n deasserts, the first write or clear SHALL be accepted on the first rising edge.

Structure
REQ-022 Package reg_file_pkg SHALL hold the FSM state enum (IDLE, CLEAR, DONE) and the default DATA_W and ADDR_W constants.
REQ-023 The clear sequencer (FSM, pointer, busy, clr_done) SHALL be a sub-module named reg_file_clr_fsm. The storage array, byte merge and bypass SHALL be in reg_file_bank.

Verification
REQ-024 Basic write/read: write 75 to entry 4 with wr_be all ones; next cycle rd_addr1=4, rd_addr2=28 -> rd_data1=75 one cycle later, rd_data2=0.
REQ-025 Byte enable and bypass: entry 9 holds 0x11223344; write 0xAABBCCDD with wr_be=4'b0101 while rd_addr1=9 in the same cycle -> rd_data1=0x11BB33DD next cycle.
REQ-026 Zero register: with ZERO_REG=1, write 0xFFFFFFFF to entry 0 -> read of entry 0 returns 0. With ZERO_REG=0, the same read returns 0xFFFFFFFF.
REQ-027 Clear sweep: fill all 32 entries with nonzero values, pulse clr_req -> busy=1 for exactly 32 cycles, then clr_done=1 for 1 cycle, all entries read 0, and a wr_en issued mid-sweep is dropped.
REQ-028 Reset mid-clear: assert rst_n=0 at sweep cycle 10 -> outputs are 0 immediately, no clr_done pulse, and a write of 5 to entry 3 is accepted on the first edge after release.
